// File: rtl/grey_pkg.sv
// Shared helpers for the Gray-code counter: width-agnostic conversions
// between binary and reflected Gray code. Callers pass the active width;
// bits above it are returned as zero.
package grey_pkg;

    localparam int GREY_MAX_WIDTH = 32;

    function automatic logic [GREY_MAX_WIDTH-1:0] f_bin2grey(
        input logic [GREY_MAX_WIDTH-1:0] bin,
        input int                        width
    );
        logic [GREY_MAX_WIDTH-1:0] mask;
        mask = (width >= GREY_MAX_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
        return (bin ^ (bin >> 1)) & mask;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GREY_MAX_WIDTH-1:0] f_gray2bin(
        input logic [GREY_MAX_WIDTH-1:0] grey,
        input int                        width
    );
        logic [GREY_MAX_WIDTH-1:0] bin;
        logic                      acc;
        bin = '0;
        acc = 1'b0;
        for (int i = GREY_MAX_WIDTH - 1; i >= 0; i--) begin
            if (i < width) begin
                acc    = acc ^ grey[i];
                bin[i] = acc;
            end else begin
                bin[i] = 1'b0;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/grey_edge_sync.sv
// Multi-stage synchroniser with rising-edge detect for one asynchronous
// step input. The chain resets to all ones so that a level already high
// when reset is released is not mistaken for a fresh edge.
module grey_edge_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic w_reset,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES:0] sync_q;

    // Shift the input through the chain; bit 0 is the first sample.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], i_async};
        end
    end

    assign o_rise = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

endmodule

// File: rtl/grey_counter_n.sv
// Gray-code up/down counter stepped by synchronised rising edges.
// Build option: define GREY_COUNTER_DECR_EN to enable the i_decr path
// (synchroniser, decrement, down-wrap and the incr/decr cancel rule).
// Without it the counter is up-only and i_decr is left unconnected inside.
module grey_counter_n
    import grey_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 3
) (
    input  logic             clk,
    input  logic             w_reset,
    input  logic             i_incr,
    input  logic             i_decr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_grey,
    output logic [WIDTH-1:0] o_bin,
    output logic             o_step,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] BIN_MAX = '1;

    logic             inc_rise;
    logic             dec_rise;
    logic [WIDTH-1:0] grey_q, grey_next;
    logic [WIDTH-1:0] bin_q, bin_next;
    logic             step_q, step_next;
    logic             wrap_q, wrap_next;

    grey_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_incr (
        .clk     (clk),
        .w_reset (w_reset),
        .i_async (i_incr),
        .o_rise  (inc_rise)
    );

`ifdef GREY_COUNTER_DECR_EN
    grey_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_decr (
        .clk     (clk),
        .w_reset (w_reset),
        .i_async (i_decr),
        .o_rise  (dec_rise)
    );
`else
    logic unused_decr;
    assign unused_decr = i_decr;
    assign dec_rise    = 1'b0;
`endif

    // Next count: load beats steps; coincident up/down edges cancel.
    always_comb begin
        bin_next  = bin_q;
        grey_next = grey_q;
        step_next = 1'b0;
        wrap_next = 1'b0;
        if (i_load) begin
            grey_next = i_load_val;
            bin_next  = WIDTH'(f_gray2bin(GREY_MAX_WIDTH'(i_load_val), WIDTH));
            step_next = 1'b1;
        end else if (inc_rise && dec_rise) begin
            step_next = 1'b0;
        end else if (inc_rise) begin
            bin_next  = bin_q + BIN_ONE;
            grey_next = WIDTH'(f_bin2grey(GREY_MAX_WIDTH'(bin_next), WIDTH));
            step_next = 1'b1;
            wrap_next = (bin_q == BIN_MAX);
        end else if (dec_rise) begin
            bin_next  = bin_q - BIN_ONE;
            grey_next = WIDTH'(f_bin2grey(GREY_MAX_WIDTH'(bin_next), WIDTH));
            step_next = 1'b1;
            wrap_next = (bin_q == '0);
        end
    end

    // Count and pulse registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            grey_q <= '0;
            bin_q  <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            grey_q <= grey_next;
            bin_q  <= bin_next;
            step_q <= step_next;
            wrap_q <= wrap_next;
        end
    end

    assign o_grey = grey_q;
    assign o_bin  = bin_q;
    assign o_step = step_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_grey_counter_n.sv
// Bench for grey_counter_n (WIDTH=6). A second instance with SYNC_STAGES=2
// is used only for the latency comparison.
module tb_grey_counter_n;

    localparam int W = 6;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         w_reset;
    logic         i_incr, i_decr, i_load;
    logic [W-1:0] i_load_val;
    logic [W-1:0] o_grey, o_bin;
    logic         o_step, o_wrap;

    logic         incr2;
    logic [W-1:0] o_grey2, o_bin2;
    logic         o_step2, o_wrap2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grey_counter_n #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .w_reset(w_reset), .i_incr(i_incr), .i_decr(i_decr),
        .i_load(i_load), .i_load_val(i_load_val),
        .o_grey(o_grey), .o_bin(o_bin), .o_step(o_step), .o_wrap(o_wrap)
    );

    grey_counter_n #(.WIDTH(W), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .w_reset(w_reset), .i_incr(incr2), .i_decr(1'b0),
        .i_load(1'b0), .i_load_val('0),
        .o_grey(o_grey2), .o_bin(o_bin2), .o_step(o_step2), .o_wrap(o_wrap2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Binary value whose Gray code is g, found by search.
    function automatic int grey_inverse(input int g);
        int r;
        r = -1;
        for (int n = 0; n < (1 << W); n++) begin
            if ((n ^ (n >> 1)) == g) r = n;
        end
        return r;
    endfunction

    // Reference model: an integer count. A step is seen at edge n when the
    // input sampled S edges earlier was high and the sample before it low.
    bit hist_i[$];
    bit hist_d[$];
    int m_bin  = 0;
    bit m_step = 1'b0;
    bit m_wrap = 1'b0;
    bit ri, rd;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (w_reset) begin
            hist_i.delete();
            hist_d.delete();
            for (int k = 0; k < 8; k++) begin
                hist_i.push_back(1'b1);
                hist_d.push_back(1'b1);
            end
            m_bin  <= 0;
            m_step <= 1'b0;
            m_wrap <= 1'b0;
        end else begin
            ri = hist_i[hist_i.size() - S] && !hist_i[hist_i.size() - S - 1];
`ifdef GREY_COUNTER_DECR_EN
            rd = hist_d[hist_d.size() - S] && !hist_d[hist_d.size() - S - 1];
`else
            rd = 1'b0;
`endif
            if (i_load) begin
                m_bin  <= grey_inverse(int'(i_load_val));
                m_step <= 1'b1;
                m_wrap <= 1'b0;
            end else if (ri && rd) begin
                m_step <= 1'b0;
                m_wrap <= 1'b0;
            end else if (ri) begin
                m_bin  <= (m_bin + 1) % (1 << W);
                m_step <= 1'b1;
                m_wrap <= (m_bin == (1 << W) - 1);
            end else if (rd) begin
                m_bin  <= (m_bin + (1 << W) - 1) % (1 << W);
                m_step <= 1'b1;
                m_wrap <= (m_bin == 0);
            end else begin
                m_step <= 1'b0;
                m_wrap <= 1'b0;
            end
            hist_i.push_back(i_incr);
            hist_d.push_back(i_decr);
            if (hist_i.size() > 16) void'(hist_i.pop_front());
            if (hist_d.size() > 16) void'(hist_d.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_bin",  int'(o_bin),  m_bin);
            check("model_grey", int'(o_grey), m_bin ^ (m_bin >> 1));
            check("model_step", int'(o_step), int'(m_step));
            check("model_wrap", int'(o_wrap), int'(m_wrap));
        end
    end

    // Transition monitor for the full-cycle sweep.
    bit           mon_en = 1'b0;
    int           step_cnt = 0;
    int           wrap_cnt = 0;
    logic [W-1:0] prev_grey = '0;
    logic [W-1:0] prev_bin = '0;

    always @(negedge clk) begin
        if (mon_en && o_step) begin
            step_cnt++;
            check("one_bit_change", $countones(o_grey ^ prev_grey), 1);
            if (o_wrap) begin
                wrap_cnt++;
                check("wrap_from", int'(prev_bin), 63);
                check("wrap_to", int'(o_bin), 0);
            end
        end
        prev_grey = o_grey;
        prev_bin  = o_bin;
    end

    typedef struct {
        logic [W-1:0] load_val;
        int           exp_bin;
    } load_vec_t;

    load_vec_t lv[7];

    initial begin
        lv[0] = '{6'b100000, 63};
        lv[1] = '{6'b000001, 1};
        lv[2] = '{6'b000011, 2};
        lv[3] = '{6'b110000, 32};
        lv[4] = '{6'b101010, 51};
        lv[5] = '{6'b111111, 42};
        lv[6] = '{6'b000000, 0};

        w_reset = 1'b1; i_incr = 1'b1; i_decr = 1'b0; i_load = 1'b0;
        i_load_val = '0; incr2 = 1'b0;

        // Reset with i_incr held high through release.
        repeat (3) @(negedge clk);
        w_reset = 1'b0;
        check("rst_grey", int'(o_grey), 0);
        check("rst_bin",  int'(o_bin),  0);
        check("rst_step", int'(o_step), 0);
        check("rst_wrap", int'(o_wrap), 0);
        chk_en = 1'b1;
        repeat (10) @(negedge clk);
        check("held_high_bin",  int'(o_bin),  0);
        check("held_high_grey", int'(o_grey), 0);
        i_incr = 1'b0;
        repeat (3) @(negedge clk);

        // 64 pulses: a full cycle back to zero with one wrap.
        mon_en = 1'b1;
        for (int p = 0; p < 64; p++) begin
            i_incr = 1'b1;
            repeat (2) @(negedge clk);
            i_incr = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        check("sweep_steps", step_cnt, 64);
        check("sweep_wraps", wrap_cnt, 1);
        check("sweep_end_bin", int'(o_bin), 0);

        // Latency: raise just before edge 1.
        i_incr = 1'b1;
        incr2  = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat3_edge%0d", e), int'(o_bin),  (e >= 4) ? 1 : 0);
            check($sformatf("lat2_edge%0d", e), int'(o_grey2), (e >= 3) ? 1 : 0);
            if (e == 3) check("lat2_step", int'(o_step2), 1);
        end
        @(negedge clk);
        i_incr = 1'b0;
        incr2  = 1'b0;
        repeat (4) @(negedge clk);
        check("lat2_bin_final", int'(o_bin2), 1);
        check("lat2_no_wrap", int'(o_wrap2), 0);

        // Load table.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            i_load = 1'b1;
            i_load_val = lv[i].load_val;
            @(posedge clk);
            #1;
            i_load = 1'b0;
            check($sformatf("load%0d_grey", i), int'(o_grey), int'(lv[i].load_val));
            check($sformatf("load%0d_bin", i),  int'(o_bin),  lv[i].exp_bin);
            check($sformatf("load%0d_step", i), int'(o_step), 1);
            check($sformatf("load%0d_wrap", i), int'(o_wrap), 0);
        end
        repeat (3) @(negedge clk);

        // Load coinciding with a step edge: step discarded.
        i_incr = 1'b1;
        repeat (3) @(negedge clk);
        i_load = 1'b1;
        i_load_val = 6'b100000;
        @(posedge clk);
        #1;
        i_load = 1'b0;
        check("ld_coinc_grey", int'(o_grey), 32);
        check("ld_coinc_bin",  int'(o_bin),  63);
        repeat (4) @(negedge clk);
        check("ld_coinc_hold", int'(o_bin), 63);
        i_incr = 1'b0;
        repeat (2) @(negedge clk);
        i_incr = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("ld_wrap_bin",  int'(o_bin),  0);
        check("ld_wrap_flag", int'(o_wrap), 1);
        check("ld_wrap_step", int'(o_step), 1);
        @(negedge clk);
        i_incr = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-count at 17 with an edge in flight.
        i_load = 1'b1;
        i_load_val = 6'b011000;
        @(negedge clk);
        i_load = 1'b0;
        i_incr = 1'b1;
        repeat (2) @(negedge clk);
        i_incr = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_bin", int'(o_bin), 17);
        i_incr = 1'b1;
        @(negedge clk);
        w_reset = 1'b1;
        @(negedge clk);
        w_reset = 1'b0;
        check("mid_reset_bin", int'(o_bin), 0);
        repeat (10) @(negedge clk);
        check("post_reset_bin",  int'(o_bin),  0);
        check("post_reset_step", int'(o_step), 0);
        i_incr = 1'b0;
        repeat (3) @(negedge clk);

`ifdef GREY_COUNTER_DECR_EN
        i_decr = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("decr_wrap_bin",  int'(o_bin),  63);
        check("decr_wrap_flag", int'(o_wrap), 1);
        @(negedge clk);
        i_decr = 1'b0;
        repeat (2) @(negedge clk);
        i_incr = 1'b1;
        i_decr = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("cancel_bin",  int'(o_bin),  63);
        check("cancel_step", int'(o_step), 0);
        @(negedge clk);
        i_incr = 1'b0;
        i_decr = 1'b0;
        repeat (3) @(negedge clk);
`else
        for (int p = 0; p < 3; p++) begin
            i_decr = 1'b1;
            repeat (2) @(negedge clk);
            i_decr = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("decr_ignored_bin",  int'(o_bin),  0);
        check("decr_ignored_grey", int'(o_grey), 0);
`endif

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            i_incr     = 1'($urandom_range(0, 1));
            i_decr     = 1'($urandom_range(0, 1));
            i_load     = ($urandom_range(0, 15) == 0);
            i_load_val = W'($urandom_range(0, 63));
        end
        @(negedge clk);
        i_incr = 1'b0;
        i_decr = 1'b0;
        i_load = 1'b0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
